// File: rtl/padd_chain_pkg.sv
// padd_pkg: shared widths, saturation bounds and slice helpers for the
// pre-adder chain.
package padd_pkg;

  localparam int DEF_WIDTH = 9;
  localparam int DEF_LANES = 5;

  // Result is one bit wider than the operands so A+B / A-B never wraps.
  function automatic int res_w(input int width);
    return width + 1;
  endfunction

  // Largest positive value representable in `width` signed bits.
  function automatic int sat_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Most negative value representable in `width` signed bits.
  function automatic int sat_min(input int width);
    return -(1 << (width - 1));
  endfunction

  // Low bit of lane `lane` inside a packed operand bus.
  function automatic int op_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Low bit of lane `lane` inside the packed result bus.
  function automatic int res_lo(input int lane, input int width);
    return lane * res_w(width);
  endfunction

endpackage

// File: rtl/padd_chain_if.sv
// padd_chain_if: operand/result bundle of the pre-adder chain. The master
// side drives operands and controls; the slave side (the chain) returns
// results, saturation flags, the cascade output and the valid strobe.
interface padd_chain_if
  import padd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LANES = DEF_LANES
) ();

  logic                            ce;
  logic                            clr;
  logic [LANES*WIDTH-1:0]          a;
  logic [LANES*WIDTH-1:0]          b;
  logic [LANES-1:0]                bsel;
  logic [LANES-1:0]                sub;
  logic [WIDTH-1:0]                sbi;
  logic                            in_valid;
  logic [WIDTH-1:0]                sbo;
  logic [LANES*res_w(WIDTH)-1:0]   dout;
  logic [LANES-1:0]                sat;
  logic                            out_valid;

  modport master (
    output ce, clr, a, b, bsel, sub, sbi, in_valid,
    input  sbo, dout, sat, out_valid
  );

  modport slave (
    input  ce, clr, a, b, bsel, sub, sbi, in_valid,
    output sbo, dout, sat, out_valid
  );

endinterface

// File: rtl/padd_chain_lane.sv
// padd_lane: one signed pre-adder lane. Holds the B operand (external or
// shifted from the neighbour), the add/sub select, optionally A, and an
// optional output register; optional clamp to WIDTH bits.
module padd_lane
  import padd_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int AREG     = 0,
  parameter int OREG     = 0,
  parameter int SATURATE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_ce,
  input  logic                     i_clr,
  input  logic [WIDTH-1:0]         i_a,
  input  logic [WIDTH-1:0]         i_b_ext,
  input  logic [WIDTH-1:0]         i_b_chain,
  input  logic                     i_bsel,
  input  logic                     i_sub,
  output logic [WIDTH-1:0]         o_b,
  output logic [res_w(WIDTH)-1:0]  o_dout,
  output logic                     o_sat
);

  localparam int RW = res_w(WIDTH);

  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic [WIDTH-1:0] w_a;
  logic [RW-1:0]    w_a_x;
  logic [RW-1:0]    w_b_x;
  logic [RW-1:0]    w_sum;
  logic [RW-1:0]    w_res;
  logic             w_clamp;

  // B operand and add/sub select are captured together in the operand stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_b   <= '0;
      r_sub <= 1'b0;
    end else if (i_clr) begin
      r_b   <= '0;
      r_sub <= 1'b0;
    end else if (i_ce) begin
      r_b   <= i_bsel ? i_b_chain : i_b_ext;
      r_sub <= i_sub;
    end
  end

  assign o_b = r_b;

  generate
    if (AREG != 0) begin : g_areg
      logic [WIDTH-1:0] r_a;

      // A registered alongside B so both operands line up
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_a <= '0;
        end else if (i_clr) begin
          r_a <= '0;
        end else if (i_ce) begin
          r_a <= i_a;
        end
      end

      assign w_a = r_a;
    end else begin : g_acomb
      assign w_a = i_a;
    end
  endgenerate

  assign w_a_x = {w_a[WIDTH-1], w_a};
  assign w_b_x = {r_b[WIDTH-1], r_b};
  assign w_sum = r_sub ? (w_a_x - w_b_x) : (w_a_x + w_b_x);

  generate
    if (SATURATE != 0) begin : g_sat
      localparam logic [RW-1:0] C_MAX = RW'(sat_max(WIDTH));
      localparam logic [RW-1:0] C_MIN = RW'(sat_min(WIDTH));

      // Out of WIDTH-bit range exactly when the two top result bits differ
      assign w_clamp = w_sum[RW-1] ^ w_sum[RW-2];
      assign w_res   = w_clamp ? (w_sum[RW-1] ? C_MIN : C_MAX) : w_sum;
    end else begin : g_nosat
      assign w_clamp = 1'b0;
      assign w_res   = w_sum;
    end
  endgenerate

  generate
    if (OREG != 0) begin : g_oreg
      logic [RW-1:0] r_dout;
      logic          r_sat;

      // Output register holds result and clamp flag for one more stage
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_dout <= '0;
          r_sat  <= 1'b0;
        end else if (i_clr) begin
          r_dout <= '0;
          r_sat  <= 1'b0;
        end else if (i_ce) begin
          r_dout <= w_res;
          r_sat  <= w_clamp;
        end
      end

      assign o_dout = r_dout;
      assign o_sat  = r_sat;
    end else begin : g_ocomb
      assign o_dout = w_res;
      assign o_sat  = w_clamp;
    end
  endgenerate

endmodule

// File: rtl/padd_chain.sv
// padd_chain: LANES pre-adder lanes with a B shift chain running from the
// top lane (fed by sbi) down to lane 0 (exposed on sbo), plus the valid
// pipeline matching the data latency.
module padd_chain
  import padd_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LANES    = DEF_LANES,
  parameter int AREG     = 0,
  parameter int OREG     = 0,
  parameter int SATURATE = 0
) (
  input  logic          clk,
  input  logic          reset,
  padd_chain_if.slave   bus
);

  localparam int RW = res_w(WIDTH);

  logic [WIDTH-1:0] w_b_q [LANES];
  logic             r_vld;

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      logic [WIDTH-1:0] w_chain;

      if (i == LANES - 1) begin : g_top
        assign w_chain = bus.sbi;
      end else begin : g_mid
        assign w_chain = w_b_q[i+1];
      end

      padd_lane #(
        .WIDTH    (WIDTH),
        .AREG     (AREG),
        .OREG     (OREG),
        .SATURATE (SATURATE)
      ) u_lane (
        .clk       (clk),
        .reset     (reset),
        .i_ce      (bus.ce),
        .i_clr     (bus.clr),
        .i_a       (bus.a[op_lo(i, WIDTH) +: WIDTH]),
        .i_b_ext   (bus.b[op_lo(i, WIDTH) +: WIDTH]),
        .i_b_chain (w_chain),
        .i_bsel    (bus.bsel[i]),
        .i_sub     (bus.sub[i]),
        .o_b       (w_b_q[i]),
        .o_dout    (bus.dout[res_lo(i, WIDTH) +: RW]),
        .o_sat     (bus.sat[i])
      );
    end
  endgenerate

  assign bus.sbo = w_b_q[0];

  // First valid stage tracks the operand stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= 1'b0;
    end else if (bus.clr) begin
      r_vld <= 1'b0;
    end else if (bus.ce) begin
      r_vld <= bus.in_valid;
    end
  end

  generate
    if (OREG != 0) begin : g_vld_oreg
      logic r_vld_o;

      // Second valid stage follows the lane output registers
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_vld_o <= 1'b0;
        end else if (bus.clr) begin
          r_vld_o <= 1'b0;
        end else if (bus.ce) begin
          r_vld_o <= r_vld;
        end
      end

      assign bus.out_valid = r_vld_o;
    end else begin : g_vld_comb
      assign bus.out_valid = r_vld;
    end
  endgenerate

endmodule

// File: tb/tb_padd_chain.sv
// Bench for padd_chain: three configurations driven with identical stimulus
// and compared against an operand-level reference model.
module tb_padd_chain;

  localparam int W  = 9;
  localparam int L  = 5;
  localparam int RW = W + 1;
  localparam int ND = 3;
  // bit d = configuration of instance d
  localparam logic [ND-1:0] C_AREG = 3'b110;
  localparam logic [ND-1:0] C_OREG = 3'b010;
  localparam logic [ND-1:0] C_SAT  = 3'b110;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic           clk;
  logic           reset;
  logic           ce;
  logic           clr;
  logic [L*W-1:0] a_v;
  logic [L*W-1:0] b_v;
  logic [L-1:0]   bsel_v;
  logic [L-1:0]   sub_v;
  logic [W-1:0]   sbi_v;
  logic           in_valid;

  logic [L*RW-1:0] got_dout [ND];
  logic [L-1:0]    got_sat  [ND];
  logic [W-1:0]    got_sbo  [ND];
  logic            got_ov   [ND];

  int n_checks;
  int n_errors;

  int m_b    [ND][L];
  int m_a    [ND][L];
  bit m_sub  [ND][L];
  int m_out  [ND][L];
  bit m_osat [ND][L];
  bit m_v1   [ND];
  bit m_v2   [ND];

  genvar g;
  generate
    for (g = 0; g < ND; g++) begin : g_dut
      padd_chain_if #(.WIDTH(W), .LANES(L)) bus ();

      assign bus.ce       = ce;
      assign bus.clr      = clr;
      assign bus.a        = a_v;
      assign bus.b        = b_v;
      assign bus.bsel     = bsel_v;
      assign bus.sub      = sub_v;
      assign bus.sbi      = sbi_v;
      assign bus.in_valid = in_valid;

      padd_chain #(
        .WIDTH    (W),
        .LANES    (L),
        .AREG     (C_AREG[g] ? 1 : 0),
        .OREG     (C_OREG[g] ? 1 : 0),
        .SATURATE (C_SAT[g] ? 1 : 0)
      ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
      );

      assign got_dout[g] = bus.dout;
      assign got_sat[g]  = bus.sat;
      assign got_sbo[g]  = bus.sbo;
      assign got_ov[g]   = bus.out_valid;
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic signed [W-1:0] t);
    return int'(t);
  endfunction

  function automatic int lane_in(input logic [L*W-1:0] v, input int i);
    logic signed [W-1:0] t;
    t = v[i*W +: W];
    return int'(t);
  endfunction

  function automatic logic [RW-1:0] lane_out(input logic [L*RW-1:0] v, input int i);
    return v[i*RW +: RW];
  endfunction

  // Exact signed sum/difference, then optional clamp to W-bit range
  function automatic int arith(input int av, input int bv, input bit s, input bit satf,
                               output bit cl);
    int r;
    r  = s ? (av - bv) : (av + bv);
    cl = 1'b0;
    if (satf && r > SMAX) begin
      r  = SMAX;
      cl = 1'b1;
    end else if (satf && r < SMIN) begin
      r  = SMIN;
      cl = 1'b1;
    end
    return r;
  endfunction

  task automatic model_clear(input int d);
    for (int i = 0; i < L; i++) begin
      m_b[d][i]    = 0;
      m_a[d][i]    = 0;
      m_sub[d][i]  = 1'b0;
      m_out[d][i]  = 0;
      m_osat[d][i] = 1'b0;
    end
    m_v1[d] = 1'b0;
    m_v2[d] = 1'b0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) model_clear(d);
  endtask

  // One rising edge of the reference: uses the operands as presented
  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      if (reset || clr) begin
        model_clear(d);
      end else if (ce) begin
        if (C_OREG[d]) begin
          for (int i = 0; i < L; i++) begin
            bit cl;
            int aeff;
            aeff = C_AREG[d] ? m_a[d][i] : lane_in(a_v, i);
            m_out[d][i]  = arith(aeff, m_b[d][i], m_sub[d][i], C_SAT[d], cl);
            m_osat[d][i] = cl;
          end
        end
        m_v2[d] = m_v1[d];
        m_v1[d] = in_valid;
        // ascending order: lane i reads lane i+1 before it is overwritten
        for (int i = 0; i < L; i++) begin
          if (!bsel_v[i])      m_b[d][i] = lane_in(b_v, i);
          else if (i == L - 1) m_b[d][i] = sx(sbi_v);
          else                 m_b[d][i] = m_b[d][i+1];
          m_sub[d][i] = sub_v[i];
          m_a[d][i]   = lane_in(a_v, i);
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int d = 0; d < ND; d++) begin
      logic [L*RW-1:0] ev;
      logic [L-1:0]    es;
      logic [W-1:0]    eb;
      bit              cl;
      int              val;
      ev = '0;
      es = '0;
      for (int i = 0; i < L; i++) begin
        if (C_OREG[d]) begin
          val = m_out[d][i];
          cl  = m_osat[d][i];
        end else begin
          val = arith(C_AREG[d] ? m_a[d][i] : lane_in(a_v, i), m_b[d][i], m_sub[d][i],
                      C_SAT[d], cl);
        end
        ev[i*RW +: RW] = val[RW-1:0];
        es[i] = cl;
      end
      val = m_b[d][0];
      eb  = val[W-1:0];
      check_val($sformatf("%s d%0d dout", tag, d), 64'(got_dout[d]), 64'(ev));
      check_val($sformatf("%s d%0d sat", tag, d), 64'(got_sat[d]), 64'(es));
      check_val($sformatf("%s d%0d sbo", tag, d), 64'(got_sbo[d]), 64'(eb));
      check_val($sformatf("%s d%0d out_valid", tag, d), 64'(got_ov[d]),
                64'(C_OREG[d] ? m_v2[d] : m_v1[d]));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] r;
    case ($urandom_range(0, 7))
      0:       r = 9'h0FF;
      1:       r = 9'h100;
      2:       r = 9'h1FF;
      3:       r = 9'h000;
      default: r = W'($urandom());
    endcase
    return r;
  endfunction

  initial begin
    logic [RW-1:0] fe [L];
    fe = '{10'h00E, 10'h00F, 10'h010, 10'h011, 10'h330};
    n_checks = 0;
    n_errors = 0;

    // reset state
    reset    = 1'b1;
    ce       = 1'b1;
    clr      = 1'b0;
    a_v      = {9'h123, 9'd4, 9'd3, 9'd2, 9'd1};
    b_v      = {9'h00D, 36'h0};
    bsel_v   = 5'b01111;
    sub_v    = '0;
    sbi_v    = '0;
    in_valid = 1'b1;
    model_reset();
    #3;
    compare_all("reset");
    check_val("reset d0 lane4 live a", 64'(lane_out(got_dout[0], 4)), 64'(10'h323));
    check_val("reset d1 dout", 64'(got_dout[1]), 64'd0);
    check_val("reset d2 dout", 64'(got_dout[2]), 64'd0);
    #1 reset = 1'b0;

    // chain fill from lane 4 toward lane 0
    for (int e = 1; e <= L; e++) begin
      tick($sformatf("fill e%0d", e));
      check_val($sformatf("fill e%0d lane%0d", e, L - e),
                64'(lane_out(got_dout[0], L - e)), 64'(fe[L-e]));
      if (e == 1) begin
        for (int i = 0; i < L - 1; i++)
          check_val($sformatf("fill e1 lane%0d", i), 64'(lane_out(got_dout[0], i)), 64'(i + 1));
      end
    end
    check_val("fill sbo", 64'(got_sbo[0]), 64'(9'h00D));

    // new value into the chain, then freeze with ce low for 3 cycles
    b_v = {9'h055, 36'h0};
    tick("refill");
    tick("refill");
    ce = 1'b0;
    a_v = {9'h1F0, 9'h00A, 9'h0B0, 9'h00C, 9'h10D};
    for (int k = 0; k < 3; k++) tick("freeze");
    ce = 1'b1;
    for (int k = 0; k < 3; k++) tick("resume");

    // async reset pulse between edges with the chain partly filled
    #3 reset = 1'b1;
    model_reset();
    #1;
    compare_all("arst");
    check_val("arst d1 dout", 64'(got_dout[1]), 64'd0);
    check_val("arst d1 sbo", 64'(got_sbo[1]), 64'd0);
    check_val("arst d1 out_valid", 64'(got_ov[1]), 64'd0);
    #1 reset = 1'b0;
    for (int k = 0; k < 3; k++) tick("post arst");

    // synchronous clear wins over ce low
    ce  = 1'b0;
    clr = 1'b1;
    tick("clr");
    check_val("clr d1 dout", 64'(got_dout[1]), 64'd0);
    check_val("clr d1 sbo", 64'(got_sbo[1]), 64'd0);
    check_val("clr d1 out_valid", 64'(got_ov[1]), 64'd0);
    clr = 1'b0;
    ce  = 1'b1;

    // subtract across the full range, then add two minimum values
    bsel_v = '0;
    a_v    = {L{9'h0FF}};
    b_v    = {L{9'h100}};
    sub_v  = '1;
    tick("sub");
    check_val("sub d0 lane0", 64'(lane_out(got_dout[0], 0)), 64'(10'h1FF));
    check_val("sub d0 sat", 64'(got_sat[0]), 64'd0);
    check_val("sub d2 lane0", 64'(lane_out(got_dout[2], 0)), 64'(10'h0FF));
    check_val("sub d2 sat", 64'(got_sat[2]), 64'(5'b11111));
    tick("sub");
    check_val("sub d1 lane0", 64'(lane_out(got_dout[1], 0)), 64'(10'h0FF));
    check_val("sub d1 sat", 64'(got_sat[1]), 64'(5'b11111));
    a_v   = {L{9'h100}};
    sub_v = '0;
    tick("addneg");
    check_val("addneg d0 lane2", 64'(lane_out(got_dout[0], 2)), 64'(10'h200));
    check_val("addneg d2 lane2", 64'(lane_out(got_dout[2], 2)), 64'(10'h300));
    check_val("addneg d2 sat", 64'(got_sat[2]), 64'(5'b11111));
    tick("addneg");
    check_val("addneg d1 lane2", 64'(lane_out(got_dout[1], 2)), 64'(10'h300));

    // single-cycle in_valid through the OREG pipeline
    in_valid = 1'b0;
    a_v      = {L{9'd5}};
    b_v      = {L{9'd3}};
    tick("vflush");
    tick("vflush");
    in_valid = 1'b1;
    tick("vpulse e0");
    check_val("vpulse e0 d1 ov", 64'(got_ov[1]), 64'd0);
    check_val("vpulse e0 d0 ov", 64'(got_ov[0]), 64'd1);
    in_valid = 1'b0;
    a_v      = {L{9'd7}};
    b_v      = {L{9'd1}};
    tick("vpulse e1");
    check_val("vpulse e1 d1 ov", 64'(got_ov[1]), 64'd1);
    check_val("vpulse e1 d1 lane0", 64'(lane_out(got_dout[1], 0)), 64'd8);
    check_val("vpulse e1 d0 ov", 64'(got_ov[0]), 64'd0);
    tick("vpulse e2");
    check_val("vpulse e2 d1 ov", 64'(got_ov[1]), 64'd0);

    // randomized operands, chain selects, enables, clears and reset pulses
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < L; i++) begin
        a_v[i*W +: W] = rnd_op();
        b_v[i*W +: W] = rnd_op();
      end
      bsel_v   = L'($urandom());
      sub_v    = L'($urandom());
      sbi_v    = rnd_op();
      in_valid = 1'($urandom());
      ce       = ($urandom_range(0, 9) != 0);
      clr      = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 59) == 0) begin
        #2 reset = 1'b1;
        model_reset();
        #1;
        compare_all("rnd arst");
        #1 reset = 1'b0;
      end else begin
        #3;
      end
      compare_all("rnd pre");
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
